// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and width helpers for the banked SRAM controller
package sram_ctrl_pkg;

    typedef enum logic {PORT_P0, PORT_P1} port_t;

    function automatic int sel_width(input int n);
        return $clog2(n);
    endfunction

    function automatic int addr_width(input int banks, input int depth);
        return $clog2(banks * depth);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// sram_bank: behavioural single-port byte-writable SRAM bank with macro-style active-low controls
module sram_bank
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 8192,
    localparam int AW = sel_width(DEPTH),
    localparam int NB = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              ceb,
    input  logic              gweb,
    input  logic [NB-1:0]     bwb,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (!ceb) begin
            if (gweb)
                q <= mem[addr];
            else
                for (int i = 0; i < NB; i++)
                    if (!bwb[i]) mem[addr][i*8 +: 8] <= d[i*8 +: 8];
        end
    end

endmodule

// File: rtl/sram_banked_ctrl.sv
// sram_banked_ctrl: fetch (P0) and load/store (P1) ports over word-interleaved byte-writable SRAM banks
module sram_banked_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_BANKS = 4,
    parameter int BANK_DEPTH = 8192,
    parameter int OUT_REG = 1,
    parameter int STARVE_LIMIT = 4,
    localparam int AW = addr_width(NUM_BANKS, BANK_DEPTH),
    localparam int BW = sel_width(NUM_BANKS),
    localparam int NB = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [AW-1:0]     p0_addr,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_we,
    input  logic [NB-1:0]     p1_be,
    input  logic [AW-1:0]     p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata
);

    localparam int RW = AW - BW;
    localparam int SW = sel_width(STARVE_LIMIT + 1);

    typedef struct packed {
        logic              en;
        logic              we;
        logic [NB-1:0]     be;
        logic [RW-1:0]     row;
        logic [DATA_W-1:0] wdata;
    } bank_req_t;

    logic [BW-1:0]     p0_bank, p1_bank, p0_bank1, p1_bank1;
    logic [SW-1:0]     starve_cnt;
    port_t             winner;
    logic              conflict, p0_acc, p1_acc;
    logic              p0_v1, p1_v1, p0_v2, p1_v2, p1_we1;
    logic [DATA_W-1:0] p0_rd, p1_rd, p0_hold, p1_hold;
    logic [DATA_W-1:0] bank_q [NUM_BANKS];

    // Acceptance is gated by RSTB so nothing reaches the banks while in reset
    always_comb begin
        p0_bank = p0_addr[BW-1:0];
        p1_bank = p1_addr[BW-1:0];
        conflict = p0_req_valid && p1_req_valid && (p0_bank == p1_bank);
        winner = (starve_cnt == SW'(STARVE_LIMIT)) ? PORT_P0 : PORT_P1;
        p0_req_ready = !conflict || (winner == PORT_P0);
        p1_req_ready = !conflict || (winner == PORT_P1);
        p0_acc = RSTB && p0_req_valid && p0_req_ready;
        p1_acc = RSTB && p1_req_valid && p1_req_ready;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB)
            starve_cnt <= '0;
        else if (p0_acc)
            starve_cnt <= '0;
        else if (conflict && starve_cnt != SW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_req_t req;
        assign req = (p1_acc && p1_bank == BW'(b)) ?
                         bank_req_t'{en: 1'b1, we: p1_we, be: p1_be, row: p1_addr[AW-1:BW], wdata: p1_wdata} :
                     (p0_acc && p0_bank == BW'(b)) ?
                         bank_req_t'{en: 1'b1, we: 1'b0, be: '0, row: p0_addr[AW-1:BW], wdata: '0} :
                         '0;
        sram_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH)) u_bank (
            .CLK  (CLK),
            .ceb  (!req.en),
            .gweb (!req.we),
            .bwb  (~req.be),
            .addr (req.row),
            .d    (req.wdata),
            .q    (bank_q[b])
        );
    end

    assign p0_rd = bank_q[p0_bank1];
    assign p1_rd = p1_we1 ? '0 : bank_q[p1_bank1];

    // hold regs keep the last response visible and double as the OUT_REG stage
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            p0_v1 <= 1'b0;
            p1_v1 <= 1'b0;
            p0_v2 <= 1'b0;
            p1_v2 <= 1'b0;
            p1_we1 <= 1'b0;
            p0_bank1 <= '0;
            p1_bank1 <= '0;
            p0_hold <= '0;
            p1_hold <= '0;
        end else begin
            p0_v1 <= p0_acc;
            p1_v1 <= p1_acc;
            p0_v2 <= p0_v1;
            p1_v2 <= p1_v1;
            p1_we1 <= p1_we;
            p0_bank1 <= p0_bank;
            p1_bank1 <= p1_bank;
            if (p0_v1) p0_hold <= p0_rd;
            if (p1_v1) p1_hold <= p1_rd;
        end
    end

    assign p0_rsp_valid = (OUT_REG != 0) ? p0_v2 : p0_v1;
    assign p1_rsp_valid = (OUT_REG != 0) ? p1_v2 : p1_v1;
    assign p0_rsp_rdata = (OUT_REG != 0 || !p0_v1) ? p0_hold : p0_rd;
    assign p1_rsp_rdata = (OUT_REG != 0 || !p1_v1) ? p1_hold : p1_rd;

endmodule
